// File: rtl/rand_share_arbiter.sv
// Round-robin arbiter sharing one free-running random word generator among
// several consumers. Each grant captures the generator's current value and is
// followed by a fixed idle gap, so no two consumers ever see the same step.
module rand_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned GAP  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [W-1:0]    rnd_in,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [W-1:0]    rnd_out,
  output logic            busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GapW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]    rnd_q, rnd_d;

  logic [NREQ-1:0] masked_req;
  logic            found;
  logic [PtrW-1:0] sel;
  logic [PtrW-1:0] idx;
  logic            eligible;

  // Rotating priority scan starting at ptr. The grant currently shown is
  // masked so a held request cannot win two cycles in a row when GAP is 0.
  always_comb begin
    masked_req = req & ~gnt_q;
    found      = 1'b0;
    sel        = '0;
    idx        = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % NREQ);
      if (!found && masked_req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign eligible = en && (gap_cnt_q == '0) && found;

  // Next-state: grant pulse, captured word, pointer advance and gap countdown.
  always_comb begin
    gnt_d     = '0;
    rnd_d     = rnd_q;
    ptr_d     = ptr_q;
    gap_cnt_d = gap_cnt_q;
    if (eligible) begin
      gnt_d     = NREQ'(1) << sel;
      rnd_d     = rnd_in;
      ptr_d     = (32'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
      gap_cnt_d = GapW'(GAP);
    end else if (en && (gap_cnt_q != '0)) begin
      // Counter freezes while en is low.
      gap_cnt_d = gap_cnt_q - 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      rnd_q     <= '0;
      ptr_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      gnt_q     <= gnt_d;
      rnd_q     <= rnd_d;
      ptr_q     <= ptr_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign rnd_out = rnd_q;
  assign busy    = (gap_cnt_q != '0);

endmodule

// File: tb/tb_rand_share_arbiter.sv
// Self-checking bench for rand_share_arbiter: two instances (GAP=3 and GAP=0)
// driven from directed steps and random traffic, checked against a
// behavioural model and a fairness scoreboard.
module tb_rand_share_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] rnd_in;
  logic [3:0] req3, req0;
  logic [3:0] gnt3, gnt0;
  logic [3:0] rnd3, rnd0;
  logic       busy3, busy0;

  int n_vec = 0;
  int n_err = 0;

  rand_share_arbiter #(.NREQ(4), .W(4), .GAP(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .rnd_in(rnd_in), .req(req3),
    .gnt(gnt3), .rnd_out(rnd3), .busy(busy3)
  );

  rand_share_arbiter #(.NREQ(4), .W(4), .GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .rnd_in(rnd_in), .req(req0),
    .gnt(gnt0), .rnd_out(rnd0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: priority index, remaining idle slots, last grant,
  // last captured word.
  typedef struct packed {
    logic [1:0] ptr;
    logic [3:0] gap;
    logic [3:0] gnt;
    logic [3:0] rnd;
  } mstate_t;

  mstate_t m3, m0;

  function automatic mstate_t step(input mstate_t s, input logic e, input logic [3:0] r,
                                   input logic [3:0] rin, input int g);
    mstate_t    n;
    logic [3:0] cand;
    int         winner;
    n      = s;
    n.gnt  = 4'b0;
    cand   = r & ~s.gnt;
    winner = -1;
    if (e && s.gap == 0 && cand != 4'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (winner < 0 && cand[(int'(s.ptr) + k) % 4]) winner = (int'(s.ptr) + k) % 4;
      end
      n.gnt = 4'b1 << winner;
      n.rnd = rin;
      n.ptr = 2'((winner + 1) % 4);
      n.gap = 4'(g);
    end else if (e && s.gap > 0) begin
      n.gap = s.gap - 4'd1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m3 <= '0;
      m0 <= '0;
    end else begin
      m3 <= step(m3, en, req3, rnd_in, 3);
      m0 <= step(m0, en, req0, rnd_in, 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enabled edges each held request has waited without a grant (GAP=3 DUT).
  int wait3 [4] = '{0, 0, 0, 0};

  task automatic check_all();
    chk("gnt3", 32'(gnt3), 32'(m3.gnt));
    chk("rnd3", 32'(rnd3), 32'(m3.rnd));
    chk("busy3", 32'(busy3), 32'(m3.gap != 0));
    chk("gnt0", 32'(gnt0), 32'(m0.gnt));
    chk("rnd0", 32'(rnd0), 32'(m0.rnd));
    chk("busy0", 32'(busy0), 32'(m0.gap != 0));
    for (int b = 0; b < 4; b++) begin
      if (!req3[b] || gnt3[b]) wait3[b] = 0;
      else if (en) wait3[b]++;
      chk("fair_wait", 32'(wait3[b] > 16), 32'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rnd_in = 4'($urandom);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt3), 32'd0);
    chk("rst_rnd", 32'(rnd3), 32'd0);
    chk("rst_busy", 32'(busy3), 32'd0);
    #1;
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) wait3[b] = 0;
  endtask

  initial begin
    logic [3:0] seq [$];
    int         at [$];
    logic       prev, saw2, any;
    int         n;

    rst_n  = 1'b0;
    en     = 1'b0;
    req3   = 4'b0;
    req0   = 4'b0;
    rnd_in = 4'($urandom);
    repeat (3) cycle();

    // Leave reset between edges; first eligible edge grants.
    #3 rst_n = 1'b1;
    en   = 1'b1;
    req3 = 4'b0001;
    cycle();
    chk("first_gnt", 32'(gnt3), 32'h1);
    // Reset in the middle of the grant cycle clears outputs at once.
    pulse_reset();
    cycle();
    chk("regrant", 32'(gnt3), 32'h1);
    req3 = 4'b0;
    repeat (5) cycle();

    // Full load from ptr=0: rotation with GAP+1 edges between grants.
    pulse_reset();
    req3 = 4'b1111;
    req0 = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (gnt3 != 4'b0) begin
        seq.push_back(gnt3);
        at.push_back(c);
      end
    end
    chk("rr_count", 32'(seq.size() >= 5), 32'd1);
    chk("rr_0", 32'(seq[0]), 32'h1);
    chk("rr_1", 32'(seq[1]), 32'h2);
    chk("rr_2", 32'(seq[2]), 32'h4);
    chk("rr_3", 32'(seq[3]), 32'h8);
    chk("rr_4", 32'(seq[4]), 32'h1);
    for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(at[k] - at[k-1]), 32'd4);

    // GAP=0 single held request: never granted on two consecutive cycles.
    req3 = 4'b0;
    req0 = 4'b0001;
    prev = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("no_consec", 32'(prev & gnt0[0]), 32'd0);
      prev = gnt0[0];
    end
    req0 = 4'b0;
    repeat (5) cycle();

    // Request to index 2 withdrawn while busy is never granted.
    req3 = 4'b0001;
    cycle();
    req3 = 4'b0100;
    cycle();
    chk("withdraw_busy", 32'(busy3), 32'd1);
    req3 = 4'b0;
    saw2 = 1'b0;
    repeat (10) begin
      cycle();
      saw2 = saw2 | gnt3[2];
    end
    chk("withdrawn", 32'(saw2), 32'd0);

    // Enable freeze with two idle slots left.
    req3 = 4'b0001;
    cycle();
    req3 = 4'b0;
    cycle();
    en   = 1'b0;
    req3 = 4'b0100;
    any  = 1'b0;
    repeat (10) begin
      cycle();
      any = any | (gnt3 != 4'b0);
    end
    chk("freeze_gnt", 32'(any), 32'd0);
    chk("freeze_busy", 32'(busy3), 32'd1);
    en = 1'b1;
    n  = 0;
    while (gnt3 == 4'b0 && n < 8) begin
      cycle();
      n++;
    end
    chk("freeze_lat", 32'(n), 32'd3);
    chk("freeze_idx", 32'(gnt3), 32'h4);

    // Wrap: ptr now 3, so 1000 wins before 0001.
    req3 = 4'b1001;
    seq.delete();
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (gnt3 != 4'b0) begin
        seq.push_back(gnt3);
        req3 = req3 & ~gnt3;
      end
    end
    chk("wrap_0", 32'(seq[0]), 32'h8);
    chk("wrap_1", 32'(seq[1]), 32'h1);

    // Random traffic with occasional enable drops.
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(9) != 0);
      for (int b = 0; b < 4; b++) begin
        if (gnt3[b]) req3[b] = 1'($urandom_range(1));
        else if (req3[b]) req3[b] = ($urandom_range(9) != 0);
        else req3[b] = ($urandom_range(3) == 0);
      end
      req0 = 4'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
